// File: rtl/ifetch32_pkg.sv
// Shared constants for the ifetch32 instruction fetch stage.
package ifetch32_pkg;
  localparam int FULLW    = 32;
  localparam int LINK_REG = 14;

  localparam logic [FULLW-1:0] PC_STEP   = FULLW'(4);
  localparam logic [FULLW-1:0] PC_AHEAD  = FULLW'(8);
  localparam logic [FULLW-1:0] NOP_INSTR = '0;
endpackage

// File: rtl/ifetch32_if.sv
// Fetch-stage bus: instruction memory port plus decoder hand-off signals.
interface ifetch32_if
  import ifetch32_pkg::*;
  ;
  logic             stall;
  logic [FULLW-1:0] imem_addr;
  logic [FULLW-1:0] imem_rdata;
  logic             ib;
  logic             bl;
  logic [FULLW-1:0] bv;
  logic [FULLW-1:0] iout;
  logic             ispb_out;
  logic [FULLW-1:0] pc_out;
  logic             lr_we;
  logic [FULLW-1:0] lr_val;

  modport master (
    input  stall, imem_rdata, ib, bl, bv,
    output imem_addr, iout, ispb_out, pc_out,
    output lr_we, lr_val
  );

  modport slave (
    output stall, imem_rdata, ib, bl, bv,
    input  imem_addr, iout, ispb_out, pc_out,
    input  lr_we, lr_val
  );
endinterface

// File: rtl/ifetch32.sv
// Instruction fetch stage: owns the PC, drives sync imem, one-slot
// branch shadow so the decoder sees ARM PC+8 semantics.
module ifetch32
  import ifetch32_pkg::*;
#(
  parameter logic [FULLW-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst,
  ifetch32_if.master bus
);

  logic [FULLW-1:0] r_pc_f;
  logic [FULLW-1:0] r_pc_d;
  logic             r_valid;
  logic             r_squash;
  logic             r_lr_we;
  logic [FULLW-1:0] r_lr_val;

  logic             w_take;
  logic [FULLW-1:0] w_target;

  assign w_take   = bus.ib && !r_squash
                  && r_valid && !bus.stall;
  assign w_target = r_pc_d + PC_AHEAD + bus.bv;

  // Stall re-presents pc_d so imem_rdata keeps the held word.
  assign bus.imem_addr = rst       ? RESET_PC :
                         bus.stall ? r_pc_d   : r_pc_f;

  assign bus.iout     = (r_valid && !r_squash)
                      ? bus.imem_rdata : NOP_INSTR;
  assign bus.ispb_out = r_squash;
  assign bus.pc_out   = r_pc_d;
  assign bus.lr_we    = r_lr_we;
  assign bus.lr_val   = r_lr_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_f   <= RESET_PC;
      r_pc_d   <= RESET_PC;
      r_valid  <= 1'b0;
      r_squash <= 1'b0;
      r_lr_we  <= 1'b0;
      r_lr_val <= '0;
    end else begin
      r_lr_we <= 1'b0;
      if (!bus.stall) begin
        r_pc_d   <= r_pc_f;
        r_pc_f   <= w_take ? w_target
                           : r_pc_f + PC_STEP;
        r_valid  <= 1'b1;
        r_squash <= w_take;
      end
      if (w_take && bus.bl) begin
        r_lr_we  <= 1'b1;
        r_lr_val <= r_pc_d + PC_STEP;
      end
    end
  end

endmodule

// File: tb/tb_ifetch32.sv
// Self-checking bench for ifetch32: directed scenarios plus a
// randomized run against a slot-level reference model.
module tb_ifetch32;
  import ifetch32_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  ifetch32_if bus ();

  ifetch32 #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5A00_0003;
  endfunction

  always @(posedge clk) bus.imem_rdata <= memw(bus.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 1'b0;
    bus.ib    = 1'b0;
    bus.bl    = 1'b0;
    bus.bv    = '0;
  endtask

  task automatic run_to(input logic [31:0] pc, output bit ok);
    int n;
    n = 0;
    while (bus.pc_out !== pc && n < 64) begin
      tick();
      n++;
    end
    ok = (bus.pc_out === pc);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL run_to timeout: pc_out=%h required=%h",
               bus.pc_out, pc);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (bus.imem_addr !== RST_PC || bus.iout !== 32'h0
        || bus.ispb_out !== 1'b0 || bus.lr_we !== 1'b0
        || bus.lr_val !== 32'h0 || bus.pc_out !== RST_PC) begin
      bad++;
      $display("FAIL reset: addr=%h iout=%h ispb=%b lrwe=%b lrv=%h pc=%h",
               bus.imem_addr, bus.iout, bus.ispb_out,
               bus.lr_we, bus.lr_val, bus.pc_out);
    end
  endtask

  task automatic test_freerun();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus.pc_out !== 32'(i * 4) || bus.iout !== memw(32'(i * 4))
          || bus.ispb_out !== 1'b0) begin
        bad++;
        $display("FAIL freerun%0d: pc=%h iout=%h ispb=%b required pc=%h iout=%h",
                 i, bus.pc_out, bus.iout, bus.ispb_out,
                 32'(i * 4), memw(32'(i * 4)));
      end
    end
  endtask

  task automatic test_branch();
    bit ok;
    run_to(32'h10, ok);
    bus.ib = 1'b1;
    bus.bv = 32'h8;
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.ispb_out !== 1'b1 || bus.iout !== 32'h0
        || bus.imem_addr !== 32'h20) begin
      bad++;
      $display("FAIL branch_shadow: ispb=%b iout=%h addr=%h required 1 0 00000020",
               bus.ispb_out, bus.iout, bus.imem_addr);
    end
    tick();
    total++;
    if (bus.pc_out !== 32'h20 || bus.iout !== memw(32'h20)
        || bus.ispb_out !== 1'b0) begin
      bad++;
      $display("FAIL branch_target: pc=%h iout=%h ispb=%b required 00000020 %h 0",
               bus.pc_out, bus.iout, bus.ispb_out, memw(32'h20));
    end
  endtask

  task automatic test_bl();
    bit ok;
    run_to(32'h40, ok);
    bus.ib = 1'b1;
    bus.bl = 1'b1;
    bus.bv = 32'hFFFF_FFF8;
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.lr_we !== 1'b1 || bus.lr_val !== 32'h44) begin
      bad++;
      $display("FAIL bl_pulse: lr_we=%b lr_val=%h required 1 00000044",
               bus.lr_we, bus.lr_val);
    end
    tick();
    total++;
    if (bus.lr_we !== 1'b0 || bus.lr_val !== 32'h44
        || bus.pc_out !== 32'h40) begin
      bad++;
      $display("FAIL bl_after: lr_we=%b lr_val=%h pc=%h required 0 00000044 00000040",
               bus.lr_we, bus.lr_val, bus.pc_out);
    end
  endtask

  task automatic test_stall();
    bus.ib = 1'b1;
    bus.bv = 32'hFFFF_FFC0;
    tick();
    idle_inputs();
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (bus.iout !== memw(32'h8) || bus.pc_out !== 32'h8
          || bus.imem_addr !== 32'h8) begin
        bad++;
        $display("FAIL stall_hold%0d: iout=%h pc=%h addr=%h required %h 00000008 00000008",
                 i, bus.iout, bus.pc_out, bus.imem_addr, memw(32'h8));
      end
      if (i < 3) tick();
    end
    bus.stall = 1'b0;
    tick();
    total++;
    if (bus.pc_out !== 32'hC || bus.iout !== memw(32'hC)) begin
      bad++;
      $display("FAIL stall_release: pc=%h iout=%h required 0000000c %h",
               bus.pc_out, bus.iout, memw(32'hC));
    end
  endtask

  task automatic test_ignored();
    bus.ib = 1'b1;
    bus.bv = 32'h100;
    tick();
    #1;
    total++;
    if (bus.ispb_out !== 1'b1) begin
      bad++;
      $display("FAIL ign_shadow_flag: ispb=%b required 1", bus.ispb_out);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.pc_out !== 32'h114 || bus.ispb_out !== 1'b0) begin
      bad++;
      $display("FAIL ign_shadow: pc=%h ispb=%b required 00000114 0",
               bus.pc_out, bus.ispb_out);
    end
    bus.ib    = 1'b1;
    bus.bv    = 32'h20;
    bus.stall = 1'b1;
    tick();
    tick();
    total++;
    if (bus.pc_out !== 32'h114 || bus.ispb_out !== 1'b0) begin
      bad++;
      $display("FAIL ign_stall: pc=%h ispb=%b required 00000114 0",
               bus.pc_out, bus.ispb_out);
    end
    bus.stall = 1'b0;
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.ispb_out !== 1'b1) begin
      bad++;
      $display("FAIL stall_then_take: ispb=%b required 1", bus.ispb_out);
    end
    tick();
    total++;
    if (bus.pc_out !== 32'h13C) begin
      bad++;
      $display("FAIL stall_take_target: pc=%h required 0000013c",
               bus.pc_out);
    end
  endtask

  task automatic test_wrap();
    bus.ib = 1'b1;
    bus.bv = 32'hFFFF_FFF0 - 32'h13C - 32'h8;
    tick();
    idle_inputs();
    tick();
    total++;
    if (bus.pc_out !== 32'hFFFF_FFF0) begin
      bad++;
      $display("FAIL wrap_setup: pc=%h required fffffff0", bus.pc_out);
    end
    bus.ib = 1'b1;
    bus.bv = 32'h10;
    tick();
    idle_inputs();
    #1;
    total++;
    if (bus.imem_addr !== 32'h8) begin
      bad++;
      $display("FAIL wrap_addr: addr=%h required 00000008", bus.imem_addr);
    end
    tick();
    total++;
    if (bus.pc_out !== 32'h8 || bus.iout !== memw(32'h8)) begin
      bad++;
      $display("FAIL wrap_target: pc=%h iout=%h required 00000008 %h",
               bus.pc_out, bus.iout, memw(32'h8));
    end
  endtask

  task automatic test_reset_shadow();
    bus.ib = 1'b1;
    bus.bl = 1'b1;
    bus.bv = 32'h40;
    tick();
    idle_inputs();
    rst = 1'b1;
    #1;
    total++;
    if (bus.ispb_out !== 1'b1 || bus.lr_we !== 1'b1
        || bus.imem_addr !== RST_PC) begin
      bad++;
      $display("FAIL rst_shadow_pre: ispb=%b lrwe=%b addr=%h required 1 1 %h",
               bus.ispb_out, bus.lr_we, bus.imem_addr, RST_PC);
    end
    tick();
    total++;
    if (bus.imem_addr !== RST_PC || bus.ispb_out !== 1'b0
        || bus.lr_we !== 1'b0 || bus.iout !== 32'h0) begin
      bad++;
      $display("FAIL rst_shadow: addr=%h ispb=%b lrwe=%b iout=%h required %h 0 0 0",
               bus.imem_addr, bus.ispb_out, bus.lr_we, bus.iout, RST_PC);
    end
    rst = 1'b0;
  endtask

  // Slot model: each unstalled edge advances one slot; a taken
  // branch yields one shadow slot at pc+4, then the target slot.
  task automatic test_random();
    int          st;
    logic [31:0] m_pc, m_tgt, m_lrv;
    logic [31:0] e_addr, e_iout;
    bit          m_lrwe;
    rst = 1'b1;
    idle_inputs();
    tick();
    st     = 0;
    m_pc   = RST_PC;
    m_tgt  = '0;
    m_lrv  = '0;
    m_lrwe = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 99) < 2);
      bus.stall = ($urandom_range(0, 99) < 25);
      bus.ib    = ($urandom_range(0, 99) < 30);
      bus.bl    = $urandom_range(0, 1) == 1;
      bus.bv    = $urandom & 32'hFFFF_FFFC;
      #1;
      if (rst) e_addr = RST_PC;
      else if (bus.stall || st == 0) e_addr = m_pc;
      else if (st == 2) e_addr = m_tgt;
      else e_addr = m_pc + 32'd4;
      e_iout = (st == 1) ? memw(m_pc) : 32'h0;
      total++;
      if (bus.imem_addr !== e_addr || bus.iout !== e_iout
          || bus.pc_out !== m_pc || bus.ispb_out !== (st == 2)
          || bus.lr_we !== m_lrwe || bus.lr_val !== m_lrv) begin
        bad++;
        $display("FAIL rand%0d: addr=%h/%h iout=%h/%h pc=%h/%h ispb=%b/%b lrwe=%b/%b lrv=%h/%h",
                 c, bus.imem_addr, e_addr, bus.iout, e_iout,
                 bus.pc_out, m_pc, bus.ispb_out, st == 2,
                 bus.lr_we, m_lrwe, bus.lr_val, m_lrv);
      end
      tick();
      if (rst) begin
        st     = 0;
        m_pc   = RST_PC;
        m_lrwe = 1'b0;
        m_lrv  = '0;
      end else begin
        m_lrwe = 1'b0;
        if (!bus.stall) begin
          if (st == 1 && bus.ib) begin
            if (bus.bl) begin
              m_lrwe = 1'b1;
              m_lrv  = m_pc + 32'd4;
            end
            m_tgt = m_pc + 32'd8 + bus.bv;
            m_pc  = m_pc + 32'd4;
            st    = 2;
          end else if (st == 2) begin
            m_pc = m_tgt;
            st   = 1;
          end else if (st == 0) begin
            st = 1;
          end else begin
            m_pc = m_pc + 32'd4;
          end
        end
      end
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_branch();
    test_bl();
    test_stall();
    test_ignored();
    test_wrap();
    test_reset_shadow();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
